// File: rtl/knn_scan_controller.sv
// Nearest-neighbour scan sequencer. It walks every stored vector and dimension of
// the vector Memory, accumulates the Manhattan distance of each vector to a query
// that is supplied one element at a time, and reports the nearest vector with a
// one-cycle done pulse.
//
// Memory handshake: mem_addr/mem_dim are stable while mem_read is high. The
// Memory samples them in FETCH and presents mem_data during the following ACC
// cycle. query_elem must be valid for query_dim (always equal to mem_dim) in ACC.
module knn_scan_controller #(
  parameter int Q     = 16,
  parameter int d     = 4,
  parameter int N     = 8,
  parameter int ACC_W = N + $clog2(d) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [d-1:0]         query_dim,
  input  logic [N-1:0]         query_elem,
  output logic                 mem_read,
  output logic [Q-1:0]         mem_addr,
  output logic [d-1:0]         mem_dim,
  input  logic [N-1:0]         mem_data,
  output logic                 busy,
  output logic                 done,
  output logic [$clog2(Q)-1:0] best_idx,
  output logic [ACC_W-1:0]     best_dist,
  output logic [2:0]           dbg_state
);

  localparam int VW = (Q > 1) ? $clog2(Q) : 1;
  localparam int JW = (d > 1) ? $clog2(d) : 1;
  localparam int QW = Q;
  localparam int DW = d;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ACC   = 3'd2,
    S_CMP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state;
  logic [VW-1:0]    v;
  logic [JW-1:0]    j;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] best;
  logic [VW-1:0]    best_i;

  logic [N-1:0]     abs_diff;
  logic [ACC_W-1:0] acc_next;
  logic             acc_wins;
  logic [ACC_W-1:0] best_next;
  logic [VW-1:0]    best_i_next;

  // Distance datapath: unsigned absolute difference and the strict-less
  // comparison that keeps the lowest index on ties.
  always_comb begin
    abs_diff    = (mem_data >= query_elem) ? (mem_data - query_elem)
                                           : (query_elem - mem_data);
    acc_next    = acc + ACC_W'(abs_diff);
    acc_wins    = (acc < best);
    best_next   = acc_wins ? acc : best;
    best_i_next = acc_wins ? v : best_i;
  end

  assign query_dim = mem_dim;
  assign dbg_state = state;

  // Scan FSM with registered Memory controls, status and results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      v         <= '0;
      j         <= '0;
      acc       <= '0;
      best      <= '1;
      best_i    <= '0;
      mem_read  <= 1'b0;
      mem_addr  <= '0;
      mem_dim   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      best_idx  <= '0;
      best_dist <= '0;
    end else if (abort && (state == S_FETCH || state == S_ACC || state == S_CMP)) begin
      // Abandon the scan; the previous scan's results stay on the outputs.
      state    <= S_IDLE;
      v        <= '0;
      j        <= '0;
      acc      <= '0;
      best     <= '1;
      best_i   <= '0;
      mem_read <= 1'b0;
      mem_addr <= '0;
      mem_dim  <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state    <= S_FETCH;
            v        <= '0;
            j        <= '0;
            acc      <= '0;
            best     <= '1;
            best_i   <= '0;
            mem_read <= 1'b1;
            mem_addr <= '0;
            mem_dim  <= '0;
            busy     <= 1'b1;
          end
        end
        S_FETCH: begin
          state <= S_ACC;
        end
        S_ACC: begin
          acc <= acc_next;
          if (j == JW'(d - 1)) begin
            state    <= S_CMP;
            mem_read <= 1'b0;
          end else begin
            state   <= S_FETCH;
            j       <= j + 1'b1;
            mem_dim <= DW'(j + 1'b1);
          end
        end
        S_CMP: begin
          best   <= best_next;
          best_i <= best_i_next;
          acc    <= '0;
          j      <= '0;
          if (v == VW'(Q - 1)) begin
            // Results are published together with the done pulse.
            state     <= S_DONE;
            v         <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            best_idx  <= best_i_next;
            best_dist <= best_next;
          end else begin
            state    <= S_FETCH;
            v        <= v + 1'b1;
            mem_read <= 1'b1;
            mem_addr <= QW'(v + 1'b1);
            mem_dim  <= '0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_knn_scan_controller.sv
// Bench for knn_scan_controller with Q=4, d=2, N=8: directed vectors, extreme
// values, abort/reset/start-while-busy cases and randomized scans, all checked
// against a plain arithmetic nearest-neighbour model.
module tb_knn_scan_controller;

  localparam int Q     = 4;
  localparam int D     = 2;
  localparam int N     = 8;
  localparam int ACC_W = N + $clog2(D) + 1;
  localparam int VW    = $clog2(Q);
  localparam int LAT   = Q * (2 * D + 1) + 1;
  localparam int W     = VW + ACC_W;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [D-1:0]     query_dim;
  logic [N-1:0]     query_elem;
  logic             mem_read;
  logic [Q-1:0]     mem_addr;
  logic [D-1:0]     mem_dim;
  logic [N-1:0]     mem_data;
  logic             busy;
  logic             done;
  logic [VW-1:0]    best_idx;
  logic [ACC_W-1:0] best_dist;
  logic [2:0]       dbg_state;

  logic [N-1:0] mem [0:Q-1][0:D-1];
  logic [N-1:0] qv  [0:D-1];

  logic [W-1:0] exp_q[$];
  int n_checks;
  int n_fail;
  int rd_cnt;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  knn_scan_controller #(.Q(Q), .d(D), .N(N), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .query_dim(query_dim), .query_elem(query_elem),
    .mem_read(mem_read), .mem_addr(mem_addr), .mem_dim(mem_dim), .mem_data(mem_data),
    .busy(busy), .done(done), .best_idx(best_idx), .best_dist(best_dist),
    .dbg_state(dbg_state)
  );

  // Synchronous-read Memory model and query source.
  always @(posedge clk) begin
    if (mem_read && int'(mem_addr) < Q && int'(mem_dim) < D)
      mem_data <= mem[int'(mem_addr)][int'(mem_dim)];
  end

  always_comb begin
    query_elem = '0;
    if (int'(query_dim) < D) query_elem = qv[int'(query_dim)];
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Continuous interface invariants.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_read) rd_cnt++;
      if (int'(mem_addr) >= Q) check("addr_range", mem_addr, 0);
      if (int'(mem_dim) >= D) check("dim_range", mem_dim, 0);
      if (query_dim !== mem_dim) check("qdim_eq_mdim", query_dim, mem_dim);
      if (mem_read && !busy) check("read_only_busy", mem_read, 0);
      if (done && mem_read) check("read_in_done", mem_read, 0);
    end
  end

  // ---------------- reference model ----------------
  function automatic void ref_model(output int bi, output int bd);
    bd = 1 << 30;
    bi = 0;
    for (int vv = 0; vv < Q; vv++) begin
      int s;
      s = 0;
      for (int jj = 0; jj < D; jj++) begin
        int a, b;
        a = int'(mem[vv][jj]);
        b = int'(qv[jj]);
        s += (a > b) ? (a - b) : (b - a);
      end
      if (s < bd) begin
        bd = s;
        bi = vv;
      end
    end
  endfunction

  task automatic load_mem(input int a0, input int a1, input int b0, input int b1,
                          input int c0, input int c1, input int e0, input int e1);
    mem[0][0] = N'(a0); mem[0][1] = N'(a1);
    mem[1][0] = N'(b0); mem[1][1] = N'(b1);
    mem[2][0] = N'(c0); mem[2][1] = N'(c1);
    mem[3][0] = N'(e0); mem[3][1] = N'(e1);
  endtask

  // ---------------- driver ----------------
  // One full scan; with poke, start is also pulsed mid-scan and during DONE.
  task automatic run_scan(input bit poke);
    int bi, bd, lat, extra;
    logic [W-1:0] e;
    logic [VW-1:0] held_idx;
    logic [ACC_W-1:0] held_dist;
    ref_model(bi, bd);
    exp_q.push_back({VW'(bi), ACC_W'(bd)});
    @(negedge clk);
    rd_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    check("busy_rise", busy, 1);
    while (!done && lat < 3 * LAT) begin
      @(negedge clk);
      lat++;
      if (poke) start = (lat == 5);
    end
    check("latency", lat, LAT);
    if (done && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("best_idx", best_idx, e[W-1:ACC_W]);
      check("best_dist", best_dist, e[ACC_W-1:0]);
      check("busy_in_done", busy, 0);
      if (poke) start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", done, 0);
    check("read_count", rd_cnt, 2 * Q * D);
    if (poke) begin
      held_idx = best_idx;
      held_dist = best_dist;
      extra = 0;
      for (int k = 0; k < 2 * LAT; k++) begin
        @(negedge clk);
        if (done || busy) extra++;
      end
      check("no_restart", extra, 0);
      check("idx_held", best_idx, held_idx);
      check("dist_held", best_dist, held_dist);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bi, bd, cnt, lat;
    logic [VW-1:0] p_idx;
    logic [ACC_W-1:0] p_dist;
    n_checks = 0;
    n_fail = 0;
    rd_cnt = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    qv[0] = 8'd3; qv[1] = 8'd4;
    load_mem(10, 10, 3, 4, 200, 0, 3, 5);
    repeat (3) @(negedge clk);
    check("rst_mem_read", mem_read, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_best_idx", best_idx, 0);
    check("rst_best_dist", best_dist, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_dim", mem_dim, 0);
    check("rst_query_dim", query_dim, 0);
    rst_n = 1'b1;

    // Directed vectors from the datasheet.
    run_scan(1'b0);
    check("t1_idx", best_idx, 1);
    check("t1_dist", best_dist, 0);
    qv[1] = 8'd5;
    run_scan(1'b0);
    check("t2_idx", best_idx, 3);
    check("t2_dist", best_dist, 0);
    qv[1] = 8'd4;
    mem[3][1] = 8'd4;
    run_scan(1'b0);
    check("tie_idx", best_idx, 1);
    check("tie_dist", best_dist, 0);

    // Extreme values.
    load_mem(255, 255, 255, 255, 255, 255, 255, 255);
    qv[0] = 8'd0; qv[1] = 8'd0;
    run_scan(1'b0);
    check("ext_idx", best_idx, 0);
    check("ext_dist", best_dist, 510);

    // Abort mid-scan: outputs keep the previous result, no done.
    load_mem(9, 1, 4, 4, 7, 7, 2, 8);
    qv[0] = 8'd4; qv[1] = 8'd5;
    p_idx = best_idx;
    p_dist = best_dist;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_read", mem_read, 0);
    check("abort_done", done, 0);
    check("abort_idx", best_idx, p_idx);
    check("abort_dist", best_dist, p_dist);
    cnt = 0;
    for (int k = 0; k < 2 * LAT; k++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("abort_no_done", cnt, 0);
    run_scan(1'b0);

    // Abort together with start in IDLE: stays idle.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_idle", busy, 0);

    // Start pulses while busy and during DONE are ignored.
    run_scan(1'b1);

    // Start held high through DONE launches a second scan.
    ref_model(bi, bd);
    @(negedge clk);
    start = 1'b1;
    lat = 0;
    while (!done && lat < 3 * LAT) begin
      @(negedge clk);
      lat++;
    end
    check("held1_idx", best_idx, bi);
    check("held1_dist", best_dist, bd);
    @(negedge clk);
    check("held_idle", busy, 0);
    @(negedge clk);
    start = 1'b0;
    check("held_restart", busy, 1);
    lat = 0;
    while (!done && lat < 3 * LAT) begin
      @(negedge clk);
      lat++;
    end
    check("held2_done", done, 1);
    check("held2_idx", best_idx, bi);

    // Randomized scans; small value ranges provoke ties.
    for (int r = 0; r < 8; r++) begin
      int hi;
      hi = (r % 2 == 0) ? 255 : 3;
      for (int vv = 0; vv < Q; vv++)
        for (int jj = 0; jj < D; jj++)
          mem[vv][jj] = N'($urandom_range(0, hi));
      for (int jj = 0; jj < D; jj++) qv[jj] = N'($urandom_range(0, hi));
      run_scan(1'b0);
    end

    // Reset mid-scan returns every output to its reset value immediately.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_read", mem_read, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_idx", best_idx, 0);
    check("mrst_dist", best_dist, 0);
    check("mrst_addr", mem_addr, 0);
    check("mrst_dim", mem_dim, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_scan(1'b0);

    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
